mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_if.sv | 29 ++
 rtl/mux.sv | 60 ++++++
 tb/tb_mux.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the select/mux datapath slice.
package mux_pkg;

  // Default data width of the mux datapath.
  localparam int MUX_WIDTH = 32;

  // Select encodings: 0 picks the register-file write data, 1 the ALU result.
  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux_if.sv
// Signal bundle for the mux datapath. The master drives data/select/enable,
// the slave (the mux itself) returns the selected and registered results.
interface mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
);

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic             sel_q;
  logic             out_zero;

  modport master (
    output in1, in2, sel, en,
    input  out, out_q, out_vld, sel_q, out_zero
  );

  modport slave (
    input  in1, in2, sel, en,
    output out, out_q, out_vld, sel_q, out_zero
  );

endinterface

// File: rtl/mux.sv
// Two-input data mux with a combinational result, a zero flag, and an
// enable-gated output register that remembers which input it captured.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld,
  output logic             sel_q,
  output logic             out_zero
);

  logic [WIDTH-1:0] w_out;
  logic             w_outZero;
  logic [WIDTH-1:0] r_outQ;
  logic             r_selQ;
  logic             r_outVld;

  // Select in1 only on a clean 0; anything else (1, X, Z) falls through to in2.
  always_comb begin
    w_out = in2;
    case (sel)
      SEL_IN1: w_out = in1;
      default: w_out = in2;
    endcase
  end

  // Zero flag follows the selected data with no clock involvement.
  always_comb begin
    w_outZero = (w_out == '0);
  end

  // Output register: reset wins over enable, otherwise capture when enabled.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_outQ   <= '0;
      r_selQ   <= 1'b0;
      r_outVld <= 1'b0;
    end else if (en) begin
      r_outQ   <= w_out;
      r_selQ   <= sel;
      r_outVld <= 1'b1;
    end
  end

  assign out      = w_out;
  assign out_zero = w_outZero;
  assign out_q    = r_outQ;
  assign sel_q    = r_selQ;
  assign out_vld  = r_outVld;

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for the mux: stimulus pushes hand-computed expectations,
// a monitor pops and compares them when the stimulus marks the outputs valid.
module tb_mux;
  import mux_pkg::*;

  localparam int W = MUX_WIDTH;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         zero;
    logic [W-1:0] q;
    logic         sq;
    logic         vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  exp_t sbQ[$];
  event checkEvt;

  mux_if #(.WIDTH(W)) bus ();

  mux #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .in1      (bus.in1),
    .in2      (bus.in2),
    .sel      (bus.sel),
    .en       (bus.en),
    .out      (bus.out),
    .out_q    (bus.out_q),
    .out_vld  (bus.out_vld),
    .sel_q    (bus.sel_q),
    .out_zero (bus.out_zero)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else
      passed++;
  endtask

  // Drive one vector at the falling edge, optionally let a rising edge pass,
  // then hand the expected response to the monitor.
  task automatic applyStimulus(
    input string name,
    input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
    input logic e, input logic r, input bit clockIt,
    input logic [W-1:0] eOut, input logic eZero,
    input logic [W-1:0] eQ, input logic eSq, input logic eVld
  );
    exp_t x;
    @(negedge clk);
    bus.in1 = a;
    bus.in2 = b;
    bus.sel = s;
    bus.en  = e;
    rst     = r;
    if (clockIt) @(posedge clk);
    #1;
    x.name = name; x.out = eOut; x.zero = eZero; x.q = eQ; x.sq = eSq; x.vld = eVld;
    sbQ.push_back(x);
    -> checkEvt;
    #1;
  endtask

  // Monitor: every time outputs are declared valid, pop and compare.
  initial begin
    exp_t x;
    forever begin
      @(checkEvt);
      if (sbQ.size() == 0) begin
        total++;
        $display("[TB] FAIL scoreboard: got an output strobe, expected a queued entry");
      end else begin
        x = sbQ.pop_front();
        checkOutput({x.name, ".out"},      bus.out,      x.out);
        checkOutput({x.name, ".out_zero"}, W'(bus.out_zero), W'(x.zero));
        checkOutput({x.name, ".out_q"},    bus.out_q,    x.q);
        checkOutput({x.name, ".sel_q"},    W'(bus.sel_q),    W'(x.sq));
        checkOutput({x.name, ".out_vld"},  W'(bus.out_vld),  W'(x.vld));
      end
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    int waitCycles;
    rst = 1'b1;
    bus.in1 = '0; bus.in2 = '0; bus.sel = 1'b0; bus.en = 1'b0;

    //             name          in1            in2            sel   en    rst   clk  out            zero  out_q          sel_q vld
    applyStimulus("reset",       32'd5,         32'd6,         1'b0, 1'b0, 1'b1, 1, 32'd5,         1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("sel0",        32'd5,         32'd6,         1'b0, 1'b0, 1'b0, 0, 32'd5,         1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("sel1",        32'd10,        32'd11,        1'b1, 1'b0, 1'b0, 0, 32'd11,        1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("negIn1",      32'hFFFFFFFE,  32'hFFFFF832,  1'b0, 1'b0, 1'b0, 0, 32'hFFFFFFFE,  1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("negIn2",      32'hFFFFFFFE,  32'hFFFFF832,  1'b1, 1'b0, 1'b0, 0, 32'hFFFFF832,  1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("capture",     32'd3,         32'd1300,      1'b1, 1'b1, 1'b0, 1, 32'd1300,      1'b0, 32'd1300,      1'b1, 1'b1);
    applyStimulus("hold",        32'd9,         32'd44,        1'b0, 1'b0, 1'b0, 1, 32'd9,         1'b0, 32'd1300,      1'b1, 1'b1);
    applyStimulus("rstOverEn",   32'd77,        32'd88,        1'b1, 1'b1, 1'b1, 1, 32'd88,        1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("postRstHold", 32'd77,        32'd88,        1'b1, 1'b0, 1'b0, 1, 32'd88,        1'b0, 32'd0,         1'b0, 1'b0);
    applyStimulus("zeroCapture", 32'd0,         32'd5,         1'b0, 1'b1, 1'b0, 1, 32'd0,         1'b1, 32'd0,         1'b0, 1'b1);
    applyStimulus("recapture",   32'h12345678,  32'd5,         1'b0, 1'b1, 1'b0, 1, 32'h12345678,  1'b0, 32'h12345678,  1'b0, 1'b1);
    applyStimulus("selX",        32'd7,         32'd7,         1'bx, 1'b0, 1'b0, 0, 32'd7,         1'b0, 32'h12345678,  1'b0, 1'b1);

    // Give the monitor a bounded window to drain anything still queued.
    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (sbQ.size() != 0) begin
      total++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", sbQ.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
